// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS generator/checker: polynomial selection,
// tap lookup, lock FSM states and a word popcount.
package prbs_pkg;

    localparam int unsigned LFSR_W = 31;

    typedef enum logic [1:0] {
        PRBS7  = 2'b00,
        PRBS9  = 2'b01,
        PRBS15 = 2'b10,
        PRBS31 = 2'b11
    } prbs_mode_t;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Primary tap is also the register length of the polynomial.
    function automatic logic [4:0] tap1(input prbs_mode_t m);
        case (m)
            PRBS7:   return 5'd7;
            PRBS9:   return 5'd9;
            PRBS15:  return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] tap2(input prbs_mode_t m);
        case (m)
            PRBS7:   return 5'd6;
            PRBS9:   return 5'd5;
            PRBS15:  return 5'd14;
            default: return 5'd28;
        endcase
    endfunction

    function automatic logic [4:0] length(input prbs_mode_t m);
        return tap1(m);
    endfunction

    function automatic logic [LFSR_W-1:0] len_mask(input prbs_mode_t m);
        return LFSR_W'((64'd1 << length(m)) - 64'd1);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational W-step Fibonacci LFSR advance. With ext_en low the register
// runs free; with ext_en high the supplied bits are shifted in instead of feedback.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [LFSR_W-1:0] state,
    input  prbs_mode_t        mode,
    input  logic              ext_en,
    input  logic [W-1:0]      ext_bits,
    output logic [LFSR_W-1:0] next_state,
    output logic [W-1:0]      pred
);

    logic [4:0]        t1;
    logic [4:0]        t2;
    logic [LFSR_W-1:0] msk;

    assign t1  = tap1(mode);
    assign t2  = tap2(mode);
    assign msk = len_mask(mode);

    // pred holds the feedback bit predicted at each step, MSB = earliest.
    always_comb begin
        logic [LFSR_W-1:0] s;
        logic              fb;
        logic              b;
        s    = state;
        fb   = 1'b0;
        b    = 1'b0;
        pred = '0;
        for (int i = W - 1; i >= 0; i--) begin
            fb      = s[t1 - 5'd1] ^ s[t2 - 5'd1];
            b       = ext_en ? ext_bits[i] : fb;
            pred[i] = fb;
            s       = ((s << 1) | LFSR_W'(b)) & msk;
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_gen_chk_nb.sv
// W-bit-per-cycle PRBS generator plus self-synchronising checker with lock
// tracking and saturating bit/error counters for BER measurement.
module prbs_gen_chk_nb
    import prbs_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned CW       = 32,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned WIN      = 64,
    parameter int unsigned LOSS_THR = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          inv,
    input  logic          gen_en,
    output logic [W-1:0]  gen_data,
    output logic          gen_valid,
    input  logic          chk_valid,
    input  logic [W-1:0]  chk_data,
    input  logic          cnt_clr,
    output logic          locked,
    output logic          err_word,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] bit_cnt
);

    localparam int unsigned CLEAN_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WIN + 1);
    localparam int unsigned BAD_W   = $clog2(LOSS_THR + 1);
    localparam int unsigned SUM_W   = CW + 1;

    prbs_mode_t        mode_e;
    logic [1:0]        mode_q;
    logic              inv_q;
    logic              cfg_chg;

    logic [LFSR_W-1:0] gen_lfsr;
    logic [LFSR_W-1:0] gen_next;
    logic [W-1:0]      gen_bits;
    logic [LFSR_W-1:0] chk_hist;
    logic [LFSR_W-1:0] chk_next;
    logic [W-1:0]      chk_rx;
    logic [W-1:0]      chk_pred;
    logic [W-1:0]      chk_err;
    logic [5:0]        err_pop;
    logic              word_bad;

    lock_state_t       state;
    lock_state_t       state_next;
    logic [CLEAN_W-1:0] clean_cnt;
    logic [CLEAN_W-1:0] clean_next;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIN_W-1:0]   win_next;
    logic [BAD_W-1:0]   bad_cnt;
    logic [BAD_W-1:0]   bad_next;

    logic              count_en;
    logic [SUM_W-1:0]  err_sum;
    logic [SUM_W-1:0]  bit_sum;

    assign mode_e  = prbs_mode_t'(mode);
    assign cfg_chg = (mode != mode_q) || (inv != inv_q);

    prbs_lfsr_step #(.W(W)) u_gen_step (
        .state      (gen_lfsr),
        .mode       (mode_e),
        .ext_en     (1'b0),
        .ext_bits   ('0),
        .next_state (gen_next),
        .pred       (gen_bits)
    );

    // Checker history is built from received bits with inversion removed.
    assign chk_rx = chk_data ^ {W{inv}};

    prbs_lfsr_step #(.W(W)) u_chk_step (
        .state      (chk_hist),
        .mode       (mode_e),
        .ext_en     (1'b1),
        .ext_bits   (chk_rx),
        .next_state (chk_next),
        .pred       (chk_pred)
    );

    assign chk_err  = chk_rx ^ chk_pred;
    assign err_pop  = popcount(32'(chk_err));
    assign word_bad = (err_pop != 6'd0);
    assign locked   = (state == LOCKED);

    assign count_en = !cfg_chg && chk_valid && (state == LOCKED);
    assign err_sum  = {1'b0, err_cnt} + SUM_W'(err_pop);
    assign bit_sum  = {1'b0, bit_cnt} + SUM_W'(W);

    // Lock FSM next state and its qualifying counters.
    always_comb begin
        state_next = state;
        clean_next = clean_cnt;
        win_next   = win_cnt;
        bad_next   = bad_cnt;
        if (cfg_chg) begin
            state_next = SEEK;
            clean_next = '0;
            win_next   = '0;
            bad_next   = '0;
        end else if (chk_valid) begin
            case (state)
                SEEK: begin
                    if (word_bad) begin
                        clean_next = '0;
                    end else if (clean_cnt == CLEAN_W'(LOCK_CNT - 1)) begin
                        state_next = LOCKED;
                        clean_next = '0;
                        win_next   = '0;
                        bad_next   = '0;
                    end else begin
                        clean_next = clean_cnt + CLEAN_W'(1);
                    end
                end
                LOCKED: begin
                    if (word_bad && (bad_cnt == BAD_W'(LOSS_THR - 1))) begin
                        state_next = SEEK;
                        clean_next = '0;
                        win_next   = '0;
                        bad_next   = '0;
                    end else if (win_cnt == WIN_W'(WIN - 1)) begin
                        win_next = '0;
                        bad_next = '0;
                    end else begin
                        win_next = win_cnt + WIN_W'(1);
                        bad_next = bad_cnt + BAD_W'(word_bad);
                    end
                end
                default: state_next = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= mode;
            inv_q     <= inv;
            gen_lfsr  <= '1;
            chk_hist  <= '0;
            gen_data  <= '0;
            gen_valid <= 1'b0;
            err_word  <= 1'b0;
            state     <= SEEK;
            clean_cnt <= '0;
            win_cnt   <= '0;
            bad_cnt   <= '0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            mode_q    <= mode;
            inv_q     <= inv;
            state     <= state_next;
            clean_cnt <= clean_next;
            win_cnt   <= win_next;
            bad_cnt   <= bad_next;
            // A config change restarts both sequences and discards this cycle's words.
            if (cfg_chg) begin
                gen_lfsr  <= '1;
                chk_hist  <= '0;
                gen_valid <= 1'b0;
                err_word  <= 1'b0;
            end else begin
                gen_valid <= gen_en;
                if (gen_en) begin
                    gen_lfsr <= gen_next;
                    gen_data <= gen_bits ^ {W{inv}};
                end
                if (chk_valid) begin
                    chk_hist <= chk_next;
                end
                err_word <= chk_valid && word_bad;
            end
            if (cnt_clr) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end else if (count_en) begin
                err_cnt <= err_sum[CW] ? '1 : err_sum[CW-1:0];
                bit_cnt <= bit_sum[CW] ? '1 : bit_sum[CW-1:0];
            end
        end
    end

endmodule

// File: doc/prbs_gen_chk_nb.md
Name: prbs_gen_chk_nb

Overview:
- Parametrised W-bit-per-cycle PRBS pattern generator plus self-synchronising checker, with selectable polynomial.
- Generator drives the stimulus/DAC path.
- Checker consumes the ADC/slicer decision word and reports lock, bit-error and bit counts for BER measurement.
- Supersedes the fixed 1-bit PRBS generator: adds width, runtime mode select, inversion and error checking.

Parameters:
- W, 8, bits generated and checked per cycle (1..32).
- CW, 32, width of the error and bit counters.
- LOCK_CNT, 16, consecutive error-free valid words needed to declare lock.
- WIN, 64, valid-word window for loss-of-lock evaluation.
- LOSS_THR, 8, errored words within one window that force loss of lock.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  2  polynomial: 00 PRBS7 (x7+x6+1), 01 PRBS9 (x9+x5+1), 10 PRBS15 (x15+x14+1), 11 PRBS31 (x31+x28+1).
- inv  in  1  invert generated and expected data.
- gen_en  in  1  advance generator by W bits this cycle.
- gen_data  out  W  generated word, MSB = earliest bit.
- gen_valid  out  1  gen_data updated this cycle.
- chk_valid  in  1  chk_data valid.
- chk_data  in  W  received word, MSB = earliest bit.
- cnt_clr  in  1  clear err_cnt and bit_cnt.
- locked  out  1  checker locked.
- err_word  out  1  one-cycle pulse: last checked word had ≥1 bit error.
- err_cnt  out  CW  saturating bit-error count, counted while locked only.
- bit_cnt  out  CW  saturating checked-bit count, counted while locked only.

Behaviour:
- Reset (rst=1 at clk edge): gen_data=0, gen_valid=0, locked=0, err_word=0, err_cnt=0, bit_cnt=0. Generator LFSR = all ones. Checker history = 0. FSM = SEEK.
- Generator: 31-bit Fibonacci LFSR, using the low N bits for the selected mode.
  - Per serial step: new = s[t1-1]^s[t2-1], then s = {s[N-2:0], new}.
  - W steps per gen_en cycle. gen_data = the W new bits ^ {W{inv}}.
  - Registered: gen_valid=1 one cycle after gen_en=1; gen_data holds when gen_en=0.
- Checker: 31-bit history of received (un-inverted) bits.
  - Per bit b: e = (b^inv) ^ h[t1-1] ^ h[t2-1]; then shift (b^inv) into h.
  - Word error = popcount of e over W bits (0..W).
  - Processed only when chk_valid=1. err_word is registered, 1 cycle after chk_valid.
  - A single channel bit error yields 3 counted errors (self-sync multiplication); this is specified behaviour.
- FSM states SEEK, LOCKED:
  - SEEK: clean-word counter increments on each clean valid word and resets to 0 on an errored word. Reaching LOCK_CNT -> LOCKED; locked=1 from the following cycle.
  - LOCKED: window counter counts valid words and errored-word counter counts errored words. If errored words reach LOSS_THR before WIN words -> SEEK, clean counter reset. Window counters restart every WIN words.
- Counters: while LOCKED and chk_valid, bit_cnt += W and err_cnt += popcount. Update lands in the same cycle err_word asserts. Both saturate at 2^CW-1 and never wrap. The word that triggers lock entry is not counted.
- cnt_clr: clears both counters next edge. It wins over a simultaneous increment: result 0, the increment is dropped. It does not affect lock.
- mode or inv change (detected by registered compare): next cycle LFSR = all ones, history = 0, FSM -> SEEK, err_word=0. Counters are held.
- gen_en and chk_valid are independent; both may be asserted every cycle.
- rst mid-operation: all state returns to reset values at that edge. No partial words are retained.

Decomposition:
- Package prbs_pkg: prbs_mode_t enum (PRBS7/9/15/31); tap constant functions tap1(mode)/tap2(mode) and length(mode); lock_state_t enum; popcount function.
- Sub-module prbs_lfsr_step: combinational W-step LFSR advance (state, mode -> next state, W bits). Shared by generator and checker; the checker drives it with received bits instead of feedback.

Test Plan:
- Reset, mode=00, inv=0, gen_en=1 for one cycle -> gen_valid=1 next cycle, gen_data=8'h02 (first PRBS7 bits 0000001 then 0).
- Loopback gen_data->chk_data, chk_valid=gen_valid, mode=00 -> locked=1 after 16 clean words, err_cnt=0, bit_cnt increments by 8 per word.
- Locked loopback, flip one bit in one word -> err_word pulses (on 1 or 2 consecutive words), err_cnt=3 total, locked stays 1.
- Locked, corrupt 8 of 64 consecutive words (random data) -> locked=0 within that window. Restore clean data -> relock after 16 clean words.
- Force err_cnt near saturation (CW=8 build) with random input while locked -> err_cnt stops at 255. cnt_clr with a simultaneous error word -> err_cnt=0.
- Switch mode 00->11 while locked, loopback continues -> locked drops next cycle, PRBS31 relock after 16 words. Repeat with inv=1 -> same lock behaviour, gen_data bitwise inverted.
